// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
// Shift-in digit buffer fed from a 7-bit segment source. The buffer is
// time-multiplexed onto a common-digit LED display. Each digit slot starts
// with a blanking gap to stop ghosting between digits, and the rest of the
// slot is PWM-dimmed to one of 16 brightness levels.

module seven_seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [6:0]            seg_in,
    input  logic                  seg_load,
    input  logic                  seg_clear,
    input  logic [3:0]            brightness,
    output logic [6:0]            seg_out,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic                  frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    // The PWM phase restarts on the last blank cycle so the first active
    // cycle of every slot sees pwm == 0. With no blanking the restart moves
    // to the last cycle of the previous slot.
    localparam logic [CNT_W-1:0] CNT_PWM_RST =
        CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : (REFRESH_DIV - 1));
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    localparam logic [6:0]            SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (ACTIVE_LOW != 0) ?
                                                {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    // Reject parameter sets the scan timing cannot honour.
    generate
        if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
            $error("seven_seg_scan_driver: NUM_DIGITS must be 1..8");
        end
        if (REFRESH_DIV <= BLANK_CYCLES + 16) begin : g_bad_refresh
            $error("seven_seg_scan_driver: REFRESH_DIV must exceed BLANK_CYCLES+16");
        end
    endgenerate

    // Digit buffer: entry 0 is the most recently loaded pattern.
    logic [6:0] digit_buf_q [NUM_DIGITS];
    logic [6:0] digit_buf_d [NUM_DIGITS];

    // Scan state.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       bri_q, bri_d;
    logic [3:0]       pwm_q, pwm_d;

    // Registered outputs.
    logic [6:0]            seg_out_q, seg_out_d;
    logic [NUM_DIGITS-1:0] dig_en_q,  dig_en_d;
    logic                  frame_tick_q, frame_tick_d;

    // Decoded scan conditions.
    logic                  cnt_wrap;
    logic                  idx_wrap;
    logic                  blank;
    logic                  lit;
    logic [6:0]            pattern;
    logic [NUM_DIGITS-1:0] onehot;

    // Buffer next state: clear wins over a simultaneous load.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_buf_d[i] = digit_buf_q[i];
        end
        if (seg_clear) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_buf_d[i] = 7'h00;
            end
        end else if (seg_load) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                digit_buf_d[i] = digit_buf_q[i-1];
            end
            digit_buf_d[0] = seg_in;
        end
    end

    // Buffer storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_buf_q[i] <= 7'h00;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_buf_q[i] <= digit_buf_d[i];
            end
        end
    end

    // Slot counter, digit index, brightness latch and PWM phase next state.
    always_comb begin
        cnt_wrap = (cnt_q == CNT_LAST);
        idx_wrap = (idx_q == IDX_LAST);
        blank    = (cnt_q < CNT_BLANK);

        cnt_d = cnt_wrap ? '0 : (cnt_q + CNT_W'(1));

        idx_d = idx_q;
        if (cnt_wrap) begin
            idx_d = idx_wrap ? '0 : (idx_q + IDX_W'(1));
        end

        // Brightness is sampled once per slot so a slot never changes duty
        // part-way through.
        bri_d = (cnt_q == '0) ? brightness : bri_q;

        pwm_d = pwm_q;
        if (cnt_q == CNT_PWM_RST) begin
            pwm_d = 4'd0;
        end else if (!blank) begin
            pwm_d = pwm_q + 4'd1;
        end

        frame_tick_d = cnt_wrap && idx_wrap;
    end

    // Scan counters and brightness latch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            idx_q <= '0;
            bri_q <= 4'd0;
            pwm_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            bri_q <= bri_d;
            pwm_q <= pwm_d;
        end
    end

    // Drive pattern for the current digit, then apply output polarity.
    always_comb begin
        lit     = !blank && (pwm_q <= bri_q);
        pattern = lit ? digit_buf_q[idx_q] : 7'h00;
        onehot  = lit ? (NUM_DIGITS'(1) << idx_q) : '0;

        if (ACTIVE_LOW != 0) begin
            seg_out_d = ~pattern;
            dig_en_d  = ~onehot;
        end else begin
            seg_out_d = pattern;
            dig_en_d  = onehot;
        end
    end

    // Output registers; reset forces the display dark immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_out_q    <= SEG_OFF;
            dig_en_q     <= DIG_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            seg_out_q    <= seg_out_d;
            dig_en_q     <= dig_en_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg_out    = seg_out_q;
    assign dig_en     = dig_en_q;
    assign frame_tick = frame_tick_q;

endmodule
